// File: rtl/cpu_clk_ctrl.sv
`timescale 1ns/1ps
// cpu_clk_ctrl
// Produces a single-cycle CPU clock-enable (cpuEn) in one of four modes chosen
// by an asynchronous switch: manual step via a debounced push button, slow
// prescaled ticks, fast prescaled ticks, or every cycle. A mode change passes
// through a short settle period during which no enable is issued. No gated
// clock is produced; the CPU runs on clk and qualifies with cpuEn.
//
// Ports
//   clk        board clock, all logic on its rising edge
//   rstN       asynchronous active-low reset
//   clkSel     [1:0] mode switch (00 step, 01 slow, 10 fast, 11 full speed)
//   stepBtn    raw active-low step button, may bounce
//   cpuEn      registered CPU clock-enable, one clk cycle per CPU step
//   activeMode [1:0] mode currently driving cpuEn
//   settling   high while a mode change is being settled
//   enCnt      [15:0] count of cpuEn pulses (zero unless enabled below)
//
// Build option
//   CPU_CLK_STEP_CNT_EN  when defined, enCnt counts cpuEn cycles and wraps
//                        FFFF->0000; when undefined, enCnt is tied to zero.
module cpu_clk_ctrl #(
    parameter logic [23:0] DIV_SLOW  = 24'd5999999,
    parameter logic [23:0] DIV_FAST  = 24'd599999,
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [1:0]  clkSel,
    input  logic        stepBtn,
    output logic        cpuEn,
    output logic [1:0]  activeMode,
    output logic        settling,
    output logic [15:0] enCnt
);

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [1:0]  selMeta;
    logic [1:0]  selSync;
    logic        btnMeta;
    logic        btnSync;
    logic        btnStable;
    logic        btnStableD;
    logic        stepReq;
    logic [15:0] dbCnt;
    logic [23:0] presc;
    logic [23:0] prescNext;
    logic [23:0] termCnt;
    logic        tick;
    logic [1:0]  settleCnt;
    logic [1:0]  settleCntNext;
    logic [1:0]  pendSel;
    logic [1:0]  pendSelNext;
    logic [1:0]  activeModeNext;
    logic        cpuEnNext;

    // Two-flop synchronizers; the button idles high (released).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            selMeta <= 2'b00;
            selSync <= 2'b00;
            btnMeta <= 1'b1;
            btnSync <= 1'b1;
        end else begin
            selMeta <= clkSel;
            selSync <= selMeta;
            btnMeta <= stepBtn;
            btnSync <= btnMeta;
        end
    end

    // Debounce: the stable value only follows the synced button after
    // DB_CYCLES consecutive disagreeing cycles. A press (stable 1->0) is
    // turned into one registered step request; releases and holds give none.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            dbCnt      <= 16'd0;
            btnStable  <= 1'b1;
            btnStableD <= 1'b1;
            stepReq    <= 1'b0;
        end else begin
            btnStableD <= btnStable;
            stepReq    <= btnStableD & ~btnStable;
            if (btnSync == btnStable) begin
                dbCnt <= 16'd0;
            end else if (dbCnt == DB_CYCLES - 16'd1) begin
                btnStable <= btnSync;
                dbCnt     <= 16'd0;
            end else begin
                dbCnt <= dbCnt + 16'd1;
            end
        end
    end

    // Terminal count follows the loaded mode, not the raw switch.
    assign termCnt  = (activeMode == 2'b10) ? DIV_FAST : DIV_SLOW;
    assign tick     = (presc == termCnt);
    assign settling = (state == SETTLE);

    // Next-state logic. The settle counter restarts whenever the synced
    // switch moves, so only a switch value held for four cycles is loaded.
    // Loading mode 11 raises cpuEn on the load edge so full speed starts in
    // the very first RUN cycle.
    always_comb begin
        stateNext      = state;
        settleCntNext  = settleCnt;
        pendSelNext    = pendSel;
        activeModeNext = activeMode;
        prescNext      = presc;
        cpuEnNext      = 1'b0;
        unique case (state)
            RUN: begin
                if (selSync != activeMode) begin
                    stateNext     = SETTLE;
                    settleCntNext = 2'd0;
                    pendSelNext   = selSync;
                    prescNext     = 24'd0;
                end else begin
                    unique case (activeMode)
                        2'b00: cpuEnNext = stepReq;
                        2'b01,
                        2'b10: begin
                            cpuEnNext = tick;
                            prescNext = tick ? 24'd0 : presc + 24'd1;
                        end
                        default: cpuEnNext = 1'b1;
                    endcase
                end
            end
            SETTLE: begin
                prescNext = 24'd0;
                if (selSync != pendSel) begin
                    pendSelNext   = selSync;
                    settleCntNext = 2'd0;
                end else if (settleCnt == 2'd3) begin
                    stateNext      = RUN;
                    activeModeNext = pendSel;
                    cpuEnNext      = (pendSel == 2'b11);
                end else begin
                    settleCntNext = settleCnt + 2'd1;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= RUN;
            settleCnt  <= 2'd0;
            pendSel    <= 2'b00;
            activeMode <= 2'b00;
            presc      <= 24'd0;
            cpuEn      <= 1'b0;
        end else begin
            state      <= stateNext;
            settleCnt  <= settleCntNext;
            pendSel    <= pendSelNext;
            activeMode <= activeModeNext;
            presc      <= prescNext;
            cpuEn      <= cpuEnNext;
        end
    end

`ifdef CPU_CLK_STEP_CNT_EN
    logic [15:0] enCntQ;

    // Free-running pulse counter; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            enCntQ <= 16'h0000;
        end else begin
            enCntQ <= enCntQ + {15'd0, cpuEn};
        end
    end

    assign enCnt = enCntQ;
`else
    assign enCnt = 16'h0000;
`endif

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DIV_SLOW, default 24'd5999999, slow-tick terminal count; period is DIV_SLOW+1 clk cycles.
REQ-002 Parameter DIV_FAST, default 24'd599999, fast-tick terminal count; period is DIV_FAST+1 clk cycles.
REQ-003 Parameter DB_CYCLES, default 16'd50000, step-button debounce agreement length in clk cycles; legal range >=2.
REQ-004 clk  input  1  board clock; all logic on posedge clk.
REQ-005 rstN  input  1  reset, asynchronous, active-low.
REQ-006 clkSel  input  2  asynchronous mode switch: 00 manual step, 01 slow, 10 fast, 11 full speed.
REQ-007 stepBtn  input  1  raw asynchronous step button, active-low, bouncy.
REQ-008 cpuEn  output  1  registered CPU clock-enable, one clk cycle per CPU step; no gated clock is produced.
REQ-009 activeMode  output  2  mode currently driving cpuEn.
REQ-010 settling  output  1  high while a mode change is in progress.
REQ-011 enCnt  output  16  count of cpuEn pulses (see Configuration).

Function
REQ-012 clkSel and stepBtn SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Debounce: counter increments each cycle the synced button differs from the stable value and clears when they agree; after DB_CYCLES consecutive disagreeing cycles the stable value takes the synced value and the counter clears.
REQ-014 A stable-value 1->0 transition SHALL produce exactly one step request; 0->1 produces none; holding the button produces no repeats.
REQ-015 Prescaler: 24-bit counter, zero in the first RUN cycle after any mode load, increments each RUN cycle, wraps to 0 after reaching the active terminal count (DIV_SLOW in mode 01, DIV_FAST in mode 10); tick asserted in the wrap cycle.
REQ-016 FSM states RUN and SETTLE; reset state RUN with activeMode=00.
REQ-017 RUN, synced clkSel==activeMode: cpuEn(next cycle) = step request (00), tick (01, 10), constant 1 (11).
REQ-018 RUN, synced clkSel!=activeMode: go to SETTLE, settle counter=0, cpuEn=0 from the next cycle.
REQ-019 SETTLE: cpuEn=0, settling=1, prescaler held at 0, step requests discarded; settle counter increments each cycle.
REQ-020 SETTLE: if synced clkSel changes value, settle counter restarts at 0.
REQ-021 SETTLE: after 4 cycles of unchanged synced clkSel, activeMode loads synced clkSel and FSM returns to RUN; settling falls in the same cycle.
REQ-022 Mode 11 in RUN: cpuEn high every cycle from the first RUN cycle after the load.
REQ-023 Slow/fast latency: first cpuEn pulse in RUN cycle DIV+2 (counter reaches DIV in cycle DIV+1, registered to cpuEn one cycle later), then every DIV+1 cycles.
REQ-024 Step latency: cpuEn pulse exactly DB_CYCLES+4 cycles after the raw stepBtn falling edge, given a bounce-free input.
REQ-025 A step request arriving while not in mode 00 SHALL be discarded, never queued.

Reset
REQ-026 Asserting rstN low at any time, including mid-SETTLE or mid-debounce, SHALL immediately force: cpuEn=0, activeMode=00, settling=0, enCnt=0, FSM=RUN, all counters 0, synchronizer and stable button flops =1 (button) / 00 (clkSel).
REQ-027 After rstN release, no spurious step pulse SHALL occur while the button is held released.

Configuration
REQ-028 Macro CPU_CLK_STEP_CNT_EN defined: enCnt increments on each cycle cpuEn=1, wraps FFFF->0000.
REQ-029 Macro absent: enCnt tied to 16'h0000, counter logic not built; all other behaviour identical.

Verification (DIV_SLOW=9, DIV_FAST=3, DB_CYCLES=4)
REQ-030 Reset, clkSel=01 held -> SETTLE entered, activeMode=01 after settle, first cpuEn 11 cycles after RUN entry, then every 10 cycles.
REQ-031 Mode 00, stepBtn low for 20 cycles with 3 one-cycle bounces first -> exactly one cpuEn pulse; release -> no pulse.
REQ-032 Mode 11 running, clkSel->10 -> cpuEn 0 for entire SETTLE, settling=1 for 4 cycles, fast ticks every 4 cycles afterward.
REQ-033 clkSel toggled 01->10->01 one cycle apart in SETTLE -> settle counter restarts, final activeMode=01, no cpuEn during SETTLE.
REQ-034 rstN pulsed low mid-SETTLE -> all outputs 0, activeMode=00, no cpuEn until a valid step.
REQ-035 With CPU_CLK_STEP_CNT_EN, mode 11 for 70000 cycles -> enCnt wraps correctly; without macro enCnt stays 0.
